// File: rtl/snake_pkg.sv
// Shared encodings for the snake step controller: headings, FSM states and widths.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DEAD = 2'd3
  } state_t;

  localparam dir_t START_DIR = DIR_RIGHT;

  localparam int LEN_W   = 5;
  localparam int SCORE_W = 8;
  localparam int DIV_W   = 4;

  localparam logic [SCORE_W-1:0] SCORE_MAX = 8'hFF;

  // Headings wrap modulo 4, so a left turn from UP lands on LEFT.
  function automatic dir_t turn_dir(input dir_t cur, input logic go_left);
    logic [1:0] c;
    logic [1:0] n;
    c = cur;
    n = go_left ? (c - 2'd1) : (c + 2'd1);
    return dir_t'(n);
  endfunction

endpackage

// File: rtl/snake_step_ctrl_if.sv
// Handshake bundle between the game environment (master) and the step controller (slave).
interface snake_step_ctrl_if;

  logic       tick;
  logic       start;
  logic       left_pulse;
  logic       right_pulse;
  logic       step_done;
  logic       food_hit;
  logic       collision;

  logic       step_req;
  logic [1:0] dir;
  logic       grow;
  logic [4:0] len;
  logic [7:0] score;
  logic [1:0] state;

  modport master (
    output tick, start, left_pulse, right_pulse, step_done, food_hit, collision,
    input  step_req, dir, grow, len, score, state
  );

  modport slave (
    input  tick, start, left_pulse, right_pulse, step_done, food_hit, collision,
    output step_req, dir, grow, len, score, state
  );

endinterface

// File: rtl/snake_tick_div.sv
// Counts speed ticks while enabled and strobes once every 'divider' ticks.
module snake_tick_div
  import snake_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             enable,
  input  logic             clear,
  input  logic [DIV_W-1:0] divider,
  output logic             step
);

  logic [DIV_W-1:0] count;
  logic [DIV_W:0]   count_inc;

  assign count_inc = {1'b0, count} + {{DIV_W{1'b0}}, 1'b1};

  // Compare with >= so a divider that shrinks mid-interval still fires promptly.
  assign step = enable && tick && (count_inc >= {1'b0, divider});

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (step) begin
      count <= '0;
    end else if (enable && tick) begin
      count <= count_inc[DIV_W-1:0];
    end
  end

endmodule

// File: rtl/snake_step_ctrl.sv
// Snake game step sequencer: paces moves from speed ticks, latches turns, tracks length/score.
// Optional SNAKE_SPEEDUP_EN shortens the step divider by one for every 4 food items eaten.
module snake_step_ctrl
  import snake_pkg::*;
#(
  parameter int TICK_DIV = 4,
  parameter int INIT_LEN = 3,
  parameter int MAX_LEN  = 31
) (
  input  logic               clk,
  input  logic               reset,
  snake_step_ctrl_if.slave   bus
);

  localparam logic [DIV_W-1:0]   DIV_BASE = DIV_W'(TICK_DIV);
  localparam logic [LEN_W-1:0]   LEN_INIT = LEN_W'(INIT_LEN);
  localparam logic [LEN_W-1:0]   LEN_MAX  = LEN_W'(MAX_LEN);

  state_t             state_q, state_d;
  dir_t               dir_q, dir_d;
  dir_t               pend_dir_q, pend_dir_d;
  logic               pend_valid_q, pend_valid_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               step_req_q, step_req_d;
  logic               grow_q, grow_d;

  logic               load;
  logic               turn_ok;
  dir_t               turn_target;
  logic               step_strobe;
  logic [DIV_W-1:0]   divider;

`ifdef SNAKE_SPEEDUP_EN
  logic [5:0] speedup;
  assign speedup = score_q[7:2];
  assign divider = ({2'b00, DIV_BASE} > speedup) ? (DIV_BASE - speedup[3:0]) : 4'd1;
`else
  assign divider = DIV_BASE;
`endif

  snake_tick_div u_tick_div (
    .clk     (clk),
    .reset   (reset),
    .tick    (bus.tick),
    .enable  (state_q == ST_RUN),
    .clear   (load),
    .divider (divider),
    .step    (step_strobe)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      dir_q        <= START_DIR;
      pend_dir_q   <= START_DIR;
      pend_valid_q <= 1'b0;
      len_q        <= LEN_INIT;
      score_q      <= '0;
      step_req_q   <= 1'b0;
      grow_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      pend_dir_q   <= pend_dir_d;
      pend_valid_q <= pend_valid_d;
      len_q        <= len_d;
      score_q      <= score_d;
      step_req_q   <= step_req_d;
      grow_q       <= grow_d;
    end
  end

  // A turn seen in the very cycle a step fires is folded into that step,
  // since dir moves on that edge and a later relative turn would be stale.
  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    pend_dir_d   = pend_dir_q;
    pend_valid_d = pend_valid_q;
    len_d        = len_q;
    score_d      = score_q;
    step_req_d   = 1'b0;
    grow_d       = 1'b0;
    load         = 1'b0;

    turn_ok     = ((state_q == ST_RUN) || (state_q == ST_WAIT)) &&
                  (bus.left_pulse ^ bus.right_pulse);
    turn_target = turn_dir(dir_q, bus.left_pulse);

    if (turn_ok && !pend_valid_q) begin
      pend_valid_d = 1'b1;
      pend_dir_d   = turn_target;
    end

    case (state_q)
      ST_IDLE, ST_DEAD: begin
        if (bus.start) begin
          load         = 1'b1;
          state_d      = ST_RUN;
          len_d        = LEN_INIT;
          score_d      = '0;
          dir_d        = START_DIR;
          pend_valid_d = 1'b0;
          pend_dir_d   = START_DIR;
        end
      end
      ST_RUN: begin
        if (step_strobe) begin
          state_d      = ST_WAIT;
          step_req_d   = 1'b1;
          dir_d        = pend_valid_d ? pend_dir_d : dir_q;
          pend_valid_d = 1'b0;
        end
      end
      ST_WAIT: begin
        if (bus.step_done) begin
          if (bus.collision) begin
            state_d = ST_DEAD;
          end else begin
            state_d = ST_RUN;
            if (bus.food_hit) begin
              grow_d  = 1'b1;
              len_d   = (len_q >= LEN_MAX) ? LEN_MAX : (len_q + 5'd1);
              score_d = (score_q == SCORE_MAX) ? score_q : (score_q + 8'd1);
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.step_req = step_req_q;
  assign bus.dir      = dir_q;
  assign bus.grow     = grow_q;
  assign bus.len      = len_q;
  assign bus.score    = score_q;
  assign bus.state    = state_q;

  // A step request only ever appears on entry to WAIT, and growth only on return to RUN.
  a_step_in_wait: assert property (@(posedge clk) disable iff (reset)
    step_req_q |-> (state_q == ST_WAIT));
  a_grow_in_run: assert property (@(posedge clk) disable iff (reset)
    grow_q |-> (state_q == ST_RUN));
  a_no_overlap: assert property (@(posedge clk) disable iff (reset)
    !(step_req_q && grow_q));

endmodule
